// File: rtl/mux41_scan_ctrl.sv
// ============================================================================
//  Module      : mux41_scan_ctrl
//  Description : Select sequencer for a 4:1 mux. Steps the selects through
//                channels w,x,y,z, holds each for DWELL cycles, samples the
//                mux output on the last cycle of each dwell, and offers the
//                assembled 4-bit word downstream over valid/ready.
//                Single-shot or continuous scanning.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux41_scan_ctrl #(
  parameter int DWELL = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             mux_out,
  output logic             s0,
  output logic             s1,
  output logic             busy,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic [3:0]       sample,
  output logic [CNT_W-1:0] scan_count
);

  // Dwell counter must be at least one bit wide even when DWELL is 1.
  localparam int             DW_W         = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DWELL_RELOAD = DW_W'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [1:0]      ch;
  logic [1:0]      sel;
  logic [DW_W-1:0] dwell;
  logic [3:0]      work;

  // Selects come straight from a register so the mux sees glitch-free lines.
  assign s1 = sel[1];
  assign s0 = sel[0];

  // Scan sequencer: all state and outputs updated here, reset aborts a scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ch           <= 2'd0;
      sel          <= 2'd0;
      dwell        <= '0;
      work         <= 4'd0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      sample       <= 4'd0;
      scan_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SCAN;
            ch    <= 2'd0;
            sel   <= 2'd0;
            dwell <= DWELL_RELOAD;
            busy  <= 1'b1;
          end
        end

        SCAN: begin
          if (dwell == '0) begin
            work[ch] <= mux_out;
            if (ch != 2'd3) begin
              ch    <= ch + 2'd1;
              sel   <= ch + 2'd1;
              dwell <= DWELL_RELOAD;
            end else begin
              // Last channel: the ch3 bit is taken directly from mux_out
              // because work[3] is only being written on this same edge.
              sample       <= {mux_out, work[2:0]};
              sample_valid <= 1'b1;
              sel          <= 2'd0;
              state        <= DONE;
            end
          end else begin
            dwell <= dwell - 1'b1;
          end
        end

        DONE: begin
          if (sample_ready) begin
            sample_valid <= 1'b0;
            scan_count   <= scan_count + 1'b1;
            if (cont) begin
              state <= SCAN;
              ch    <= 2'd0;
              sel   <= 2'd0;
              dwell <= DWELL_RELOAD;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state        <= IDLE;
          sel          <= 2'd0;
          busy         <= 1'b0;
          sample_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux41_scan_ctrl.sv
// ============================================================================
//  Module      : tb_mux41_scan_ctrl
//  Description : Randomised scoreboard bench for mux41_scan_ctrl. A driver
//                plays the role of the mux, presenting per-channel levels and
//                deliberate wrong levels off the capture edges; a monitor
//                checks every handshake against queued expected words.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux41_scan_ctrl;

  localparam int DWELL = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             cont;
  logic             mux_out;
  logic             s0;
  logic             s1;
  logic             busy;
  logic             sample_valid;
  logic             sample_ready;
  logic [3:0]       sample;
  logic [CNT_W-1:0] scan_count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int hs_count  = 0;

  logic [3:0]       exp_q[$];
  logic [CNT_W-1:0] model_count = '0;

  mux41_scan_ctrl #(.DWELL(DWELL), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cont         (cont),
    .mux_out      (mux_out),
    .s0           (s0),
    .s1           (s1),
    .busy         (busy),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample       (sample),
    .scan_count   (scan_count)
  );

  // 10-time-unit clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Scoreboard monitor: samples mid-low-phase, well away from the rising edge.
  always begin
    @(negedge clk);
    #2;
    if (!rst && sample_valid && sample_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_handshake", 32'(sample), 32'hFFFF);
      end else begin
        check("sample_word", 32'(sample), 32'(exp_q.pop_front()));
      end
      check("count_before_hs", 32'(scan_count), 32'(model_count));
      model_count = model_count + 1'b1;
      hs_count++;
    end
  end

  // Plays out one scan starting just after the edge that launched it.
  // Off-capture cycles present the true level, or its inverse when noise=1,
  // so only the capture-edge levels should reach the sample word.
  task automatic scan_body(input logic [3:0] word, input bit noise);
    int ch;
    exp_q.push_back(word);
    for (int j = 1; j <= 4 * DWELL; j++) begin
      @(negedge clk);
      start = 1'b0;
      ch = (j - 1) / DWELL;
      check("sel_step", 32'({s1, s0}), 32'(ch));
      check("valid_mid_scan", 32'(sample_valid), 32'd0);
      check("busy_scan", 32'(busy), 32'd1);
      if (j % DWELL == 0) mux_out = word[ch];
      else                mux_out = noise ? ~word[ch] : word[ch];
      @(posedge clk);
    end
  endtask

  // Watchdog so the bench cannot hang.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] w;
    int         hs0;
    rst          = 1'b1;
    start        = 1'b0;
    cont         = 1'b0;
    mux_out      = 1'b0;
    sample_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_sel", 32'({s1, s0}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_count", 32'(scan_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single shot, word 0101, ready high
    start = 1'b1;
    @(posedge clk);
    scan_body(4'b0101, 1'b0);
    @(negedge clk);
    check("t2_valid", 32'(sample_valid), 32'd1);
    check("t2_sample", 32'(sample), 32'b0101);
    check("t2_sel_done", 32'({s1, s0}), 32'd0);
    @(negedge clk);
    check("t2_valid_drop", 32'(sample_valid), 32'd0);
    check("t2_idle", 32'(busy), 32'd0);
    check("t2_count", 32'(scan_count), 32'd1);
    repeat (2) @(negedge clk);
    check("t2_stay_idle", 32'(busy), 32'd0);

    // Back-pressure: ready low for 5 cycles, start pulse ignored
    sample_ready = 1'b0;
    start = 1'b1;
    @(posedge clk);
    scan_body(4'b0101, 1'b0);
    hs0 = hs_count;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = (k == 2);
      check("t3_valid_hold", 32'(sample_valid), 32'd1);
      check("t3_sample_hold", 32'(sample), 32'b0101);
      check("t3_sel_hold", 32'({s1, s0}), 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    sample_ready = 1'b1;
    @(negedge clk);
    check("t3_released", 32'(sample_valid), 32'd0);
    check("t3_idle", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("t3_one_handshake", 32'(hs_count - hs0), 32'd1);
    check("t3_count", 32'(scan_count), 32'd2);

    // Continuous: 0101 then 1010 back to back
    cont = 1'b1;
    start = 1'b1;
    @(posedge clk);
    scan_body(4'b0101, 1'b0);
    @(negedge clk);
    check("t4_valid1", 32'(sample_valid), 32'd1);
    mux_out = 1'b0;
    @(posedge clk);
    scan_body(4'b1010, 1'b0);
    @(negedge clk);
    check("t4_valid2", 32'(sample_valid), 32'd1);
    check("t4_sample2", 32'(sample), 32'b1010);
    cont = 1'b0;
    @(negedge clk);
    check("t4_idle", 32'(busy), 32'd0);

    // Noise on non-capture cycles, random words
    for (int n = 0; n < 4; n++) begin
      w = 4'($urandom_range(0, 15));
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      scan_body(w, 1'b1);
      @(negedge clk);
      check("t5_sample", 32'(sample), 32'(w));
      @(negedge clk);
    end

    // Reset mid-scan at ch=2, checked before any clock edge
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 2 * DWELL; j++) begin
      @(negedge clk);
      start = 1'b0;
      mux_out = 1'($urandom_range(0, 1));
      @(posedge clk);
    end
    @(negedge clk);
    check("t1_at_ch2", 32'({s1, s0}), 32'd2);
    #1 rst = 1'b1;
    #1;
    check("t1_async_sel", 32'({s1, s0}), 32'd0);
    check("t1_async_busy", 32'(busy), 32'd0);
    check("t1_async_valid", 32'(sample_valid), 32'd0);
    check("t1_async_sample", 32'(sample), 32'd0);
    check("t1_async_count", 32'(scan_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_count = '0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("t1_idle_after", 32'(busy), 32'd0);
    check("t1_no_valid", 32'(sample_valid), 32'd0);

    // 256 continuous scans: count reaches 255 then wraps to 0
    cont = 1'b1;
    start = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 256; n++) begin
      scan_body(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      @(negedge clk);
      if (n == 255) begin
        check("t6_count_255", 32'(scan_count), 32'd255);
        cont = 1'b0;
      end
      @(posedge clk);
    end
    @(negedge clk);
    check("t6_count_wrap", 32'(scan_count), 32'd0);
    check("t6_idle", 32'(busy), 32'd0);
    check("t6_queue_drained", 32'(exp_q.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
